// File: rtl/mem_resp_stage_pkg.sv
// rtl/mem_resp_stage_pkg.sv - shared load encodings, bus widths and parameter checks for the M stage
package mem_resp_stage_pkg;

    localparam int LD_OP_W     = 4;
    localparam int MD_DEST_W   = 5;
    localparam int MD_RESULT_W = 32;

    typedef enum logic [LD_OP_W-1:0] {
        LD_NONE = 4'b0000,
        LD_B    = 4'b0001,
        LD_H    = 4'b0011,
        LD_BU   = 4'b0101,
        LD_HU   = 4'b0111,
        LD_W    = 4'b1111
    } ld_op_e;

    function automatic bit data_w_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/mem_resp_stage_if.sv
// rtl/mem_resp_stage_if.sv - EX->M and M->WB pipeline handshake bundle
interface mem_resp_stage_if #(
    parameter int DATA_W = 32,
    parameter int PAY_W  = 200
);
    localparam int AW = $clog2(DATA_W / 8);

    logic             EM_valid;
    logic             M_allowin;
    logic [PAY_W-1:0] EM_payload;
    logic [31:0]      EM_result;
    logic             EM_req;
    logic [3:0]       EM_ld_op;
    logic [AW-1:0]    EM_addr_lo;
    logic             EM_gr_we;
    logic [4:0]       EM_dest;

    logic             W_allowin;
    logic             MW_valid;
    logic [PAY_W-1:0] MW_payload;
    logic [31:0]      MW_result;
    logic             MW_gr_we;
    logic [4:0]       MW_dest;

    modport master (
        output EM_valid, EM_payload, EM_result, EM_req, EM_ld_op, EM_addr_lo,
               EM_gr_we, EM_dest, W_allowin,
        input  M_allowin, MW_valid, MW_payload, MW_result, MW_gr_we, MW_dest
    );

    modport slave (
        input  EM_valid, EM_payload, EM_result, EM_req, EM_ld_op, EM_addr_lo,
               EM_gr_we, EM_dest, W_allowin,
        output M_allowin, MW_valid, MW_payload, MW_result, MW_gr_we, MW_dest
    );

endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed lane of the read bus and extends it to 32 bits
module mem_load_align
    import mem_resp_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [AW-1:0]     addr_lo,
    input  logic [3:0]        ld_op,
    output logic [31:0]       result
);

    logic [31:0] word_v;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic        half_ok;
    logic        word_ok;

    // Shifting by the byte offset puts every lane at bit 0, so one slice serves all widths.
    assign word_v  = 32'(data >> {addr_lo, 3'b000});
    assign half_v  = word_v[15:0];
    assign byte_v  = word_v[7:0];
    assign half_ok = !addr_lo[0];
    assign word_ok = (addr_lo[1:0] == 2'b00);

    always_comb begin
        result = 32'h0;
        case (ld_op)
            LD_B:  result = {{24{byte_v[7]}}, byte_v};
            LD_BU: result = {24'h0, byte_v};
            LD_H:  result = half_ok ? {{16{half_v[15]}}, half_v} : 32'h0;
            LD_HU: result = half_ok ? {16'h0, half_v} : 32'h0;
            LD_W:  result = word_ok ? word_v : 32'h0;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - M pipeline stage: waits for data-SRAM responses, aligns loads, drops orphaned responses
module mem_resp_stage
    import mem_resp_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PAY_W      = 200,
    parameter int CANCEL_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    mem_resp_stage_if.slave        bus,
    input  logic                   data_rvalid,
    input  logic [DATA_W-1:0]      data_rdata,
    input  logic                   ex_en,
    output logic [MD_DEST_W-1:0]   MD_dest,
    output logic [MD_RESULT_W-1:0] MD_result,
    output logic                   MD_stall,
    output logic                   resp_err
);

    localparam int AW = $clog2(DATA_W / 8);
    localparam int CW = $clog2(CANCEL_MAX + 1);
    localparam int SW = CW + 2;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("mem_resp_stage: DATA_W must be 32 or 64");
    end

    logic              M_valid;
    logic [PAY_W-1:0]  payload_M;
    logic [31:0]       result_M;
    logic              req_M;
    logic [3:0]        ld_op_M;
    logic [AW-1:0]     addr_lo_M;
    logic              gr_we_M;
    logic [4:0]        dest_M;
    logic              data_buf_v;
    logic [DATA_W-1:0] data_buf;
    logic [CW-1:0]     cancel_cnt;
    logic [CW-1:0]     cancel_nxt;
    logic [SW-1:0]     cnt_sum;

    logic              data_ok;
    logic              ready_go;
    logic              cancel_full;
    logic              m_allowin;
    logic              accept;
    logic              leave;
    logic              discard;
    logic              consume;
    logic              stray;
    logic              orphan_m;
    logic              orphan_ex;
    logic [DATA_W-1:0] load_data;
    logic [31:0]       load_result;
    logic [31:0]       final_result;

    assign data_ok     = data_buf_v || (data_rvalid && (cancel_cnt == '0));
    assign ready_go    = !req_M || data_ok;
    assign cancel_full = (cancel_cnt == CW'(CANCEL_MAX));
    assign m_allowin   = !cancel_full && (!M_valid || (ready_go && bus.W_allowin));
    assign accept      = bus.EM_valid && m_allowin && !ex_en;
    assign leave       = M_valid && ready_go && bus.W_allowin;

    // Orphans are drained first; only then can a response belong to the instruction in M.
    assign discard = data_rvalid && (cancel_cnt != '0);
    assign consume = data_rvalid && (cancel_cnt == '0) && M_valid && req_M && !data_buf_v;
    assign stray   = data_rvalid && (cancel_cnt == '0) && !(M_valid && req_M && !data_buf_v);

    assign orphan_m  = M_valid && req_M && !data_ok;
    assign orphan_ex = bus.EM_valid && bus.EM_req && m_allowin;

    always_comb begin
        cnt_sum = SW'(cancel_cnt) - SW'(discard);
        if (ex_en) begin
            cnt_sum = cnt_sum + SW'(orphan_m) + SW'(orphan_ex);
        end
        if (cnt_sum > SW'(CANCEL_MAX)) begin
            cancel_nxt = CW'(CANCEL_MAX);
        end else begin
            cancel_nxt = cnt_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            M_valid <= 1'b0;
        end else if (ex_en) begin
            M_valid <= 1'b0;
        end else if (m_allowin) begin
            M_valid <= bus.EM_valid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            payload_M <= '0;
            result_M  <= '0;
            req_M     <= 1'b0;
            ld_op_M   <= '0;
            addr_lo_M <= '0;
            gr_we_M   <= 1'b0;
            dest_M    <= '0;
        end else if (accept) begin
            payload_M <= bus.EM_payload;
            result_M  <= bus.EM_result;
            req_M     <= bus.EM_req;
            ld_op_M   <= bus.EM_ld_op;
            addr_lo_M <= bus.EM_addr_lo;
            gr_we_M   <= bus.EM_gr_we;
            dest_M    <= bus.EM_dest;
        end
    end

    // A consumed response is held here so the request is never re-issued while WB stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_buf_v <= 1'b0;
            data_buf   <= '0;
        end else if (ex_en || leave) begin
            data_buf_v <= 1'b0;
        end else if (consume) begin
            data_buf_v <= 1'b1;
            data_buf   <= data_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cancel_cnt <= '0;
            resp_err   <= 1'b0;
        end else begin
            cancel_cnt <= cancel_nxt;
            if (stray) begin
                resp_err <= 1'b1;
            end
        end
    end

    assign load_data = data_buf_v ? data_buf : data_rdata;

    mem_load_align #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_align (
        .data    (load_data),
        .addr_lo (addr_lo_M),
        .ld_op   (ld_op_M),
        .result  (load_result)
    );

    assign final_result = (ld_op_M != LD_NONE) ? load_result : result_M;

    assign bus.M_allowin  = m_allowin;
    assign bus.MW_valid   = M_valid && ready_go;
    assign bus.MW_payload = payload_M;
    assign bus.MW_result  = final_result;
    assign bus.MW_gr_we   = gr_we_M;
    assign bus.MW_dest    = dest_M;

    assign MD_dest   = (M_valid && gr_we_M) ? dest_M : '0;
    assign MD_result = final_result;
    assign MD_stall  = M_valid && gr_we_M && req_M && (ld_op_M != LD_NONE) && !data_ok;

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb/tb_mem_resp_stage.sv - directed self-checking bench for mem_resp_stage
module tb_mem_resp_stage;
    import mem_resp_stage_pkg::*;

    localparam int DW = 64;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          ex_en;
    logic [4:0]    MD_dest;
    logic [31:0]   MD_result;
    logic          MD_stall;
    logic          resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_resp_stage_if #(.DATA_W(DW), .PAY_W(PW)) bus ();

    mem_resp_stage #(.DATA_W(DW), .PAY_W(PW), .CANCEL_MAX(3)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .ex_en       (ex_en),
        .MD_dest     (MD_dest),
        .MD_result   (MD_result),
        .MD_stall    (MD_stall),
        .resp_err    (resp_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  a;
        logic [63:0] d;
        logic [31:0] e;
    } vec_t;

    vec_t vecs [8] = '{
        '{4'b0001, 3'd1, 64'h0000_0000_0000_8000, 32'hFFFF_FF80},
        '{4'b0101, 3'd7, 64'h9A00_0000_0000_0000, 32'h0000_009A},
        '{4'b0011, 3'd2, 64'h0000_0000_8001_0000, 32'hFFFF_8001},
        '{4'b0011, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000},
        '{4'b1111, 3'd4, 64'h8765_4321_0000_0000, 32'h8765_4321},
        '{4'b1111, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000},
        '{4'b1001, 3'd0, 64'h0000_0000_0000_00FF, 32'h0000_0000},
        '{4'b0111, 3'd6, 64'hABCD_0000_0000_0000, 32'h0000_ABCD}
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] a, input logic [31:0] res,
                        input logic req, input logic we, input logic [4:0] d);
        bus.EM_valid   = 1'b1;
        bus.EM_ld_op   = op;
        bus.EM_addr_lo = a;
        bus.EM_result  = res;
        bus.EM_req     = req;
        bus.EM_gr_we   = we;
        bus.EM_dest    = d;
        bus.EM_payload = res[15:0] ^ 16'hA5A5;
    endtask

    initial begin
        rstn           = 1'b0;
        data_rvalid    = 1'b0;
        data_rdata     = '0;
        ex_en          = 1'b0;
        bus.EM_valid   = 1'b0;
        bus.EM_payload = '0;
        bus.EM_result  = '0;
        bus.EM_req     = 1'b0;
        bus.EM_ld_op   = 4'b0000;
        bus.EM_addr_lo = '0;
        bus.EM_gr_we   = 1'b0;
        bus.EM_dest    = '0;
        bus.W_allowin  = 1'b1;

        repeat (2) cyc();
        check("rst_mw_valid", bus.MW_valid, 1'b0);
        check("rst_allowin", bus.M_allowin, 1'b1);
        check("rst_md_stall", MD_stall, 1'b0);
        check("rst_md_dest", MD_dest, 5'd0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_cancel_cnt", dut.cancel_cnt, 2'd0);
        check("rst_mw_result", bus.MW_result, 32'h0);
        check("rst_mw_payload", bus.MW_payload, 16'h0);
        rstn = 1'b1;
        cyc();

        // Alignment table, response in the first M cycle
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, 32'h0, 1'b1, 1'b1, 5'd4);
            cyc();
            bus.EM_valid = 1'b0;
            data_rvalid  = 1'b1;
            data_rdata   = vecs[i].d;
            #2;
            check($sformatf("vec%0d_valid", i), bus.MW_valid, 1'b1);
            check($sformatf("vec%0d_result", i), bus.MW_result, vecs[i].e);
            check($sformatf("vec%0d_stall", i), MD_stall, 1'b0);
            check($sformatf("vec%0d_md_dest", i), MD_dest, 5'd4);
            cyc();
            data_rvalid = 1'b0;
        end
        #2;
        check("vec_drain_valid", bus.MW_valid, 1'b0);

        // ld.hu with a response delayed by three cycles
        send(LD_HU, 3'd6, 32'h0, 1'b1, 1'b1, 5'd6);
        cyc();
        bus.EM_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("delay%0d_stall", k), MD_stall, 1'b1);
            check($sformatf("delay%0d_valid", k), bus.MW_valid, 1'b0);
            cyc();
        end
        data_rvalid = 1'b1;
        data_rdata  = 64'hABCD_0000_0000_0000;
        #2;
        check("delay_stall_end", MD_stall, 1'b0);
        check("delay_valid", bus.MW_valid, 1'b1);
        check("delay_result", bus.MW_result, 32'h0000_ABCD);
        cyc();
        data_rvalid = 1'b0;

        // Response while WB is stalled for two cycles
        send(LD_W, 3'd4, 32'h0, 1'b1, 1'b1, 5'd8);
        cyc();
        bus.EM_valid  = 1'b0;
        bus.W_allowin = 1'b0;
        data_rvalid   = 1'b1;
        data_rdata    = 64'h1122_3344_5566_7788;
        #2;
        check("wstall0_valid", bus.MW_valid, 1'b1);
        check("wstall0_result", bus.MW_result, 32'h1122_3344);
        check("wstall0_allowin", bus.M_allowin, 1'b0);
        cyc();
        data_rvalid = 1'b0;
        data_rdata  = '0;
        #2;
        check("wstall1_valid", bus.MW_valid, 1'b1);
        check("wstall1_result", bus.MW_result, 32'h1122_3344);
        check("wstall1_stall", MD_stall, 1'b0);
        cyc();
        bus.W_allowin = 1'b1;
        #2;
        check("wrise_result", bus.MW_result, 32'h1122_3344);
        check("wrise_allowin", bus.M_allowin, 1'b1);
        cyc();
        #2;
        check("wdone_valid", bus.MW_valid, 1'b0);
        check("wdone_resp_err", resp_err, 1'b0);

        // Non-load pass-through and gr_we=0 forwarding
        send(LD_NONE, 3'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd3);
        cyc();
        bus.EM_valid = 1'b0;
        #2;
        check("alu_valid", bus.MW_valid, 1'b1);
        check("alu_result", bus.MW_result, 32'hDEAD_BEEF);
        check("alu_md_result", MD_result, 32'hDEAD_BEEF);
        check("alu_md_dest", MD_dest, 5'd3);
        check("alu_payload", bus.MW_payload, 16'h1B4A);
        cyc();
        send(LD_NONE, 3'd0, 32'h1234_5678, 1'b0, 1'b0, 5'd3);
        cyc();
        bus.EM_valid = 1'b0;
        #2;
        check("nowe_md_dest", MD_dest, 5'd0);
        check("nowe_gr_we", bus.MW_gr_we, 1'b0);
        check("nowe_valid", bus.MW_valid, 1'b1);
        cyc();

        // Flush while M waits, then flush with an EX request: two orphans
        send(LD_W, 3'd0, 32'h0, 1'b1, 1'b1, 5'd7);
        cyc();
        bus.EM_valid = 1'b0;
        ex_en = 1'b1;
        #2;
        check("flush_wait_stall", MD_stall, 1'b1);
        cyc();
        send(LD_W, 3'd0, 32'h0, 1'b1, 1'b1, 5'd10);
        #2;
        check("flush1_cnt", dut.cancel_cnt, 2'd1);
        check("flush1_valid", bus.MW_valid, 1'b0);
        check("flush1_allowin", bus.M_allowin, 1'b1);
        cyc();
        ex_en = 1'b0;
        send(LD_B, 3'd0, 32'h0, 1'b1, 1'b1, 5'd9);
        #2;
        check("flush2_cnt", dut.cancel_cnt, 2'd2);
        check("flush2_valid", bus.MW_valid, 1'b0);
        cyc();
        bus.EM_valid = 1'b0;
        data_rvalid  = 1'b1;
        data_rdata   = 64'hAA;
        #2;
        check("orph0_valid", bus.MW_valid, 1'b0);
        check("orph0_stall", MD_stall, 1'b1);
        cyc();
        data_rdata = 64'hBB;
        #2;
        check("orph1_cnt", dut.cancel_cnt, 2'd1);
        check("orph1_valid", bus.MW_valid, 1'b0);
        cyc();
        data_rdata = 64'h7F;
        #2;
        check("orph_done_cnt", dut.cancel_cnt, 2'd0);
        check("orph_done_valid", bus.MW_valid, 1'b1);
        check("orph_done_result", bus.MW_result, 32'h0000_007F);
        cyc();
        data_rvalid = 1'b0;
        #2;
        check("orph_resp_err", resp_err, 1'b0);
        check("orph_idle_valid", bus.MW_valid, 1'b0);

        // Saturate the cancel counter at CANCEL_MAX
        send(LD_W, 3'd0, 32'h0, 1'b1, 1'b1, 5'd7);
        cyc();
        ex_en = 1'b1;
        cyc();
        cyc();
        cyc();
        ex_en = 1'b0;
        bus.EM_valid = 1'b0;
        #2;
        check("sat_cnt", dut.cancel_cnt, 2'd3);
        check("sat_allowin", bus.M_allowin, 1'b0);
        cyc();
        bus.EM_valid = 1'b1;
        data_rvalid  = 1'b1;
        #2;
        check("sat_allowin_disc", bus.M_allowin, 1'b0);
        cyc();
        bus.EM_valid = 1'b0;
        data_rvalid  = 1'b0;
        #2;
        check("sat_cnt_after", dut.cancel_cnt, 2'd2);
        check("sat_allowin_after", bus.M_allowin, 1'b1);
        check("sat_not_taken", bus.MW_valid, 1'b0);
        data_rvalid = 1'b1;
        cyc();
        cyc();
        data_rvalid = 1'b0;
        #2;
        check("sat_drained_cnt", dut.cancel_cnt, 2'd0);
        check("sat_resp_err", resp_err, 1'b0);
        cyc();

        // Stray response sets a sticky error
        data_rvalid = 1'b1;
        data_rdata  = '0;
        #2;
        check("stray_before", resp_err, 1'b0);
        cyc();
        data_rvalid = 1'b0;
        #2;
        check("stray_set", resp_err, 1'b1);
        cyc();
        cyc();
        #2;
        check("stray_sticky", resp_err, 1'b1);

        // Asynchronous reset while a load waits
        send(LD_W, 3'd0, 32'h0, 1'b1, 1'b1, 5'd12);
        cyc();
        bus.EM_valid = 1'b0;
        #2;
        check("arst_pre_stall", MD_stall, 1'b1);
        check("arst_pre_dest", MD_dest, 5'd12);
        rstn = 1'b0;
        #1;
        check("arst_valid", bus.MW_valid, 1'b0);
        check("arst_stall", MD_stall, 1'b0);
        check("arst_dest", MD_dest, 5'd0);
        check("arst_resp_err", resp_err, 1'b0);
        check("arst_allowin", bus.M_allowin, 1'b1);
        check("arst_cnt", dut.cancel_cnt, 2'd0);
        cyc();
        rstn = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
